// File: rtl/serial_mag_cmp.sv
// Bit-serial MSB-first unsigned magnitude comparator with start/busy/done handshake.
// Fixed latency of WIDTH shift cycles; the first differing bit pair decides the result.

module serial_mag_cmp_gt1 (
    input  logic x_i,
    input  logic y_i,
    output logic gt_o
);
    assign gt_o = x_i & ~y_i;
endmodule

module serial_mag_cmp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic [CW-1:0]    cnt_q;
    logic             decided_q, wgt_q, wlt_q;
    logic             decided_d, wgt_d, wlt_d;
    logic             busy_q, done_q, gt_q, eq_q, lt_q;
    logic             g, l;

    serial_mag_cmp_gt1 u_a_gt_b (.x_i(sa_q[WIDTH-1]), .y_i(sb_q[WIDTH-1]), .gt_o(g));
    serial_mag_cmp_gt1 u_b_gt_a (.x_i(sb_q[WIDTH-1]), .y_i(sa_q[WIDTH-1]), .gt_o(l));

    // Once a decision is latched, later bit pairs cannot alter it.
    always_comb begin
        decided_d = decided_q | g | l;
        wgt_d     = decided_q ? wgt_q : g;
        wlt_d     = decided_q ? wlt_q : l;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            wgt_q     <= 1'b0;
            wlt_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q      <= a;
                        sb_q      <= b;
                        cnt_q     <= CW'(WIDTH - 1);
                        decided_q <= 1'b0;
                        wgt_q     <= 1'b0;
                        wlt_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa_q      <= sa_q << 1;
                    sb_q      <= sb_q << 1;
                    decided_q <= decided_d;
                    wgt_q     <= wgt_d;
                    wlt_q     <= wlt_d;
                    if (cnt_q == '0) begin
                        // LSB edge: publish the word result, undecided means equal.
                        gt_q    <= wgt_d;
                        lt_q    <= wlt_d;
                        eq_q    <= ~decided_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;
endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed-vector bench for serial_mag_cmp with a queue-based result scoreboard.
module tb_serial_mag_cmp;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, gt, eq, lt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];
    logic [2:0] prev;

    serial_mag_cmp #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("result_gt_eq_lt", {29'd0, gt, eq, lt}, {29'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // One full compare; results must stay at prev until the done edge.
    task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] exp);
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("held_after_start", {29'd0, gt, eq, lt}, {29'd0, prev});
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            chk("busy_in_shift", {31'd0, busy}, 32'd1);
            chk("no_done_in_shift", {31'd0, done}, 32'd0);
            chk("held_in_shift", {29'd0, gt, eq, lt}, {29'd0, prev});
        end
        @(negedge clk);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("done_cleared", {31'd0, done}, 32'd0);
        prev = exp;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; prev = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {29'd0, gt, eq, lt}, 32'd0);
        reset_n = 1'b1;

        run(8'h05, 8'h03, 3'b100);
        run(8'h7F, 8'h80, 3'b001);
        run(8'hA5, 8'hA5, 3'b010);
        run(8'hFF, 8'h00, 3'b100);
        run(8'h80, 8'h81, 3'b001);

        // Continuous start: launches only at relative edges 0, 10, 20.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b010);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("held_start_busy", {31'd0, busy}, {31'd0, ((k % 10) < W) ? 1'b1 : 1'b0});
            chk("held_start_done", {31'd0, done}, {31'd0, ((k % 10) == W) ? 1'b1 : 1'b0});
            if (k == 2)  a = 8'h30;
            if (k == 12) a = 8'h20;
            if (k == 20) start = 1'b0;
        end
        prev = 3'b010;

        // Reset at relative edge 4 aborts the operation silently.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h02;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {29'd0, gt, eq, lt}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_still_idle", {31'd0, busy}, 32'd0);
        prev = 3'b000;
        run(8'h01, 8'h02, 3'b001);

        // Result hold: gt held through an eq compare until its done edge.
        run(8'hC3, 8'h3C, 3'b100);
        run(8'h55, 8'h55, 3'b010);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_mag_cmp.md
# serial_mag_cmp

Bit-serial, MSB-first magnitude comparator for two WIDTH-bit unsigned operands. It sits directly upstream of the 1-bit greater-than cell. Each cycle it presents one bit pair to two instances of that cell, `a>b` and `b>a`, and consumes their outputs to build a registered word-level result. A start/busy/done handshake lets a controller launch one comparison at a time and read the held result afterwards.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range ≥1.
- `clk`  input  1: single clock; all state changes on rising edge.
- `reset_n`  input  1: synchronous, active-low reset.
- `start`  input  1: launch request, sampled only in IDLE.
- `a`  input  WIDTH: operand A, unsigned, sampled on the accepted-start edge.
- `b`  input  WIDTH: operand B, unsigned, sampled on the accepted-start edge.
- `busy`  output  1: high while in SHIFT.
- `done`  output  1: one-cycle pulse, high while in DONE.
- `gt`  output  1: registered result, A > B.
- `eq`  output  1: registered result, A == B.
- `lt`  output  1: registered result, A < B.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE, `start`=1:
  - load `a`/`b` into shift registers sa/sb;
  - bit counter := WIDTH-1;
  - decided := 0;
  - go to SHIFT.
- IDLE, `start`=0: stay in IDLE.
- SHIFT, each edge:
  - bit pair (sa[WIDTH-1], sb[WIDTH-1]) drives the two gt cells, giving g = a_bit>b_bit and l = b_bit>a_bit;
  - if decided=0 and g=1: working result := GT, decided := 1;
  - if decided=0 and l=1: working result := LT, decided := 1;
  - once decided=1, later bits never change the working result;
  - shift sa/sb left by 1, zero-fill;
  - decrement counter.
- SHIFT, counter == 0: the edge processing the LSB goes to DONE and copies the working result into `gt`/`eq`/`lt`.
  - If decided is still 0 after the LSB, the result is EQ.
- DONE: `done`=1 for exactly one cycle; next edge goes unconditionally to IDLE.
- `start` in SHIFT or DONE is ignored. No queuing; operands are not re-sampled.
- `gt`/`eq`/`lt` are one-hot after the first completion. They are held unchanged through later IDLE/SHIFT cycles and update only on the SHIFT→DONE edge.
- Fixed latency: no early exit, even when the MSBs already differ.

## Timing
- Accepted-start edge = edge 0.
  - `busy`=1 from after edge 0 through after edge WIDTH-1.
  - Bits are processed on edges 1..WIDTH.
  - After edge WIDTH: `busy`=0, `done`=1, results valid.
  - After edge WIDTH+1: `done`=0, state IDLE.
- A new start can be accepted at edge WIDTH+2 at the earliest. Minimum issue interval is WIDTH+2 cycles.
- WIDTH=1: single SHIFT cycle; `done` after edge 1.
- Reset values (`reset_n`=0 at an edge, takes priority over everything):
  - state IDLE;
  - `busy`=0, `done`=0;
  - `gt`=0, `eq`=0, `lt`=0 (the only all-zero result state);
  - shift registers, counter and decided cleared.
- Reset mid-SHIFT aborts with no `done` pulse.
- Reset in the DONE cycle clears `done` and the results on that edge.
- `start`=1 together with `reset_n`=0 is ignored. IDLE is entered with no launch.
- Outputs are registered only. There is no combinational path from `start`/`a`/`b` to any output.

## Test plan
- Reset:
  - assert `reset_n`=0 for 2 edges → `busy`=0, `done`=0, `gt`/`eq`/`lt`=000;
  - then pulse `start` with a=8'h05, b=8'h03 → `busy` high 8 cycles, `done` pulse after edge 8, `gt`/`eq`/`lt`=100.
- Ordering and equality, one run each with WIDTH=8:
  - a=8'h7F, b=8'h80 → `lt`=1, only after edge 8, which confirms no early exit;
  - a=b=8'hA5 → `eq`=1;
  - a=8'hFF, b=8'h00 → `gt`=1.
- LSB-only difference: a=8'h80, b=8'h81 → `lt`=1. Earlier equal bits must not set decided.
- Ignored start: hold `start`=1 continuously → launches at edges 0, 10, 20 only. Change `a` during SHIFT → the result reflects the operands captured at edge 0.
- Reset mid-op: launch a=8'h01, b=8'h02, assert `reset_n`=0 at edge 4 → no `done` pulse, outputs 000, `busy`=0. A fresh start after release produces a normal result.
- Result hold: after a `gt` result, launch an `eq` compare → `gt`=1 held through all SHIFT cycles, switching to `eq`=1 exactly at the `done` edge.
